// File: rtl/bus_responder_if.sv
// Handshake side of the hmc-6502 external bus (request, direction, address, stall, strobe).
// The shared tristate data bus stays a plain inout on the responder so it can be wired-OR'd by several slaves.
interface bus_responder_if;
  logic        req;
  logic        rw;
  logic [15:0] addr;
  logic        rdy;
  logic        ack;

  modport slave  (input req, rw, addr, output rdy, ack);
  modport master (output req, rw, addr, input rdy, ack);
endinterface

// File: rtl/bus_responder.sv
// Memory-mapped 8-byte responder with programmable wait states: scratch, status, write counter, timer, ID.
// Define BUS_RESPONDER_TIMER_EN to build the free-running timer at offset 6 and its overflow flag.
//
// state  | meaning
// S_IDLE | waiting for a hitting request; latches offset, rw and write data on accept
// S_WAIT | rdy low, wait counter running down to 1
// S_ACK  | one-cycle strobe; read data driven, write committed at the closing edge
module bus_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'hD000,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [7:0]  DEV_ID      = 8'h65
) (
  input  logic           clk,
  input  logic           reset,
  bus_responder_if.slave bus,
  inout  wire  [7:0]     data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [2:0]  off_l;
  logic        rw_l;
  logic [7:0]  wdata_l;

  logic [7:0]  scratch [4];
  logic        write_seen;
  logic [7:0]  wcount;
  logic [7:0]  timer_val;
  logic        timer_ovf;

  logic        hit;
  logic        accept;
  logic        commit;
  logic        data_en;
  logic [7:0]  rdata;

  assign hit    = bus.req && (bus.addr[15:3] == BASE_ADDR[15:3]);
  assign accept = (state == S_IDLE) && hit;
  assign commit = (state == S_ACK) && !rw_l;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
      S_WAIT: if (wait_cnt == 4'd1) state_nxt = S_ACK;
      S_ACK:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.rdy = (state != S_WAIT);
    bus.ack = (state == S_ACK);
    data_en = (state == S_ACK) && rw_l;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 4'd0;
      off_l    <= 3'd0;
      rw_l     <= 1'b1;
      wdata_l  <= 8'h00;
    end else if (accept) begin
      wait_cnt <= 4'(WAIT_STATES);
      off_l    <= bus.addr[2:0];
      rw_l     <= bus.rw;
      wdata_l  <= data;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Every write commits and sets write_seen, so a clear of bit0 is always overridden.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scratch    <= '{default: 8'h00};
      write_seen <= 1'b0;
      wcount     <= 8'h00;
    end else if (commit) begin
      write_seen <= 1'b1;
      wcount     <= wcount + 8'd1;
      if (!off_l[2]) scratch[off_l[1:0]] <= wdata_l;
    end
  end

`ifdef BUS_RESPONDER_TIMER_EN
  logic timer_load;
  logic timer_wrap;
  logic ovf_clr;

  assign timer_load = commit && (off_l == 3'd6);
  assign timer_wrap = !timer_load && (timer_val == 8'hFF);
  assign ovf_clr    = commit && (off_l == 3'd4) && wdata_l[7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_val <= 8'h00;
      timer_ovf <= 1'b0;
    end else begin
      timer_val <= timer_load ? wdata_l : timer_val + 8'd1;
      if (timer_wrap)   timer_ovf <= 1'b1;
      else if (ovf_clr) timer_ovf <= 1'b0;
    end
  end
`else
  assign timer_val = 8'h00;
  assign timer_ovf = 1'b0;
`endif

  always_comb begin
    rdata = 8'h00;
    case (off_l)
      3'd0, 3'd1, 3'd2, 3'd3: rdata = scratch[off_l[1:0]];
      3'd4: rdata = {timer_ovf, 6'b000000, write_seen};
      3'd5: rdata = wcount;
      3'd6: rdata = timer_val;
      3'd7: rdata = DEV_ID;
      default: rdata = 8'h00;
    endcase
  end

  assign data = data_en ? rdata : 8'bzzzz_zzzz;

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-mapped slave on the hmc-6502 external address/data bus: the responder end of the CPU bus cycle that the core's tristate bus latches initiate. Decodes an 8-byte window at a parameterized base address, inserts a programmable number of wait states via `rdy`, drives read data onto the shared tristate data bus and commits write data to an internal register bank. Used as the reference peripheral for bus-protocol bring-up and as a scratch/ID/counter device in system sims.

## Interface
- `BASE_ADDR`, 16'hD000, window base; must be 8-byte aligned (low 3 bits zero)
- `WAIT_STATES`, 2, wait cycles inserted per access; legal range 0..15
- `DEV_ID`, 8'h65, constant returned at offset 7

- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  1  CPU bus-cycle request; address/rw/data valid while high
- `rw`  in  1  1 = read, 0 = write (6502 convention)
- `addr`  in  16  byte address
- `data`  inout  8  shared tristate data bus; driven only when reading in ACK
- `rdy`  out  1  0 = stall CPU (wait state in progress)
- `ack`  out  1  one-cycle transfer-complete strobe

## Operation
- Hit: `addr[15:3] == BASE_ADDR[15:3]`; offset = `addr[2:0]`.
- FSM states IDLE, WAIT, ACK.
  - IDLE: on edge with `req`=1 and hit, latch offset, `rw`, write data; go WAIT (WAIT_STATES>0, wait counter loaded with WAIT_STATES) else ACK. Miss or `req`=0: stay IDLE.
  - WAIT: counter decrements each edge; at edge where counter==1, go ACK.
  - ACK: one cycle; go IDLE unconditionally.
- Register map:
  - 0-3: scratch R/W, 8 bits each.
  - 4: status. bit0 = write-seen (sticky, set on any committed write), bit7 = timer overflow (timer build only, else 0), others 0. Write: each 1 bit clears the corresponding flag; 0 bits no effect.
  - 5: write counter; +1 per committed write to any offset (including itself), wraps 255->0; writes otherwise ignored.
  - 6: timer (see Configuration); without timer reads 8'h00, writes ignored.
  - 7: `DEV_ID`, read-only; writes ignored except counter/status side effects.
- Writes commit at the rising edge ending ACK, from latched data. Reads: `data` = selected register during ACK only, value as of start of ACK.
- Outputs: `rdy` = 0 only in WAIT; `ack` = 1 only in ACK; `data` hi-Z in all other states and for writes.

## Timing
- Latency from accepting edge to `ack`: WAIT_STATES+1 cycles (1 for WAIT_STATES=0).
- Back-to-back: `req` held high and hitting in the cycle after ACK starts a new transaction at that IDLE edge; throughput one access per WAIT_STATES+2 cycles.
- `req` dropped or `addr` changed during WAIT/ACK: in-flight access completes with latched values.
- Reset (any time, including mid-WAIT/ACK): FSM IDLE, `rdy`=1, `ack`=0, `data` hi-Z, all registers, counters, flags, timer = 0; pending write discarded.
- Write to status bit0 and committed write in same access: set wins (flag stays 1).

## Configuration
- `BUS_RESPONDER_TIMER_EN` defined: offset 6 is an 8-bit free-running timer, +1 every clock, wraps 255->0 setting status bit7 on wrap. Committed write to offset 6 loads the written value that edge (load wins over increment). Overflow and clear of bit7 on same edge: set wins.
- Undefined: no timer logic; offset 6 reads 0, status bit7 always 0.

## Test plan
- Reset: drive `reset`=0 mid-WAIT -> `rdy`=1, `ack`=0, `data`=Z immediately; after release, reads of offsets 0-6 return 8'h00, offset 7 returns 8'h65.
- Write 8'hA5 to 16'hD002, WAIT_STATES=2 -> `rdy` low exactly 2 cycles, `ack` 1 cycle; subsequent read returns 8'hA5, offset 5 reads 8'h01, status reads 8'h01.
- Miss: `req` with addr 16'hD008 and 16'hCFFF -> no `rdy` drop, no `ack`, `data` Z, no register change.
- WAIT_STATES=0 back-to-back: 4 consecutive writes with `req` held -> `ack` every 2nd cycle, `rdy` never low, counter reads 8'h04; 256 further writes -> counter wraps to 8'h04.
- Status clear: write 8'h01 to offset 4 -> next read of offset 4 returns 8'h01 (set wins on same access); read after a write to offset 0 then clear-write ... verify clear only when no concurrent write commit is impossible -> documented set-wins.
- Timer (`BUS_RESPONDER_TIMER_EN`): write 8'hFE to offset 6, after 2 cycles status bit7 = 1; write 8'h80 to offset 4 -> bit7 clears; undefined build -> offset 6 always 8'h00.
